// File: rtl/dtl_address_decoder.sv
// dtl_address_decoder: 1-to-N DTL address decoder with per-burst channel locking; DTL_DECODER_ERROR_RESP_EN enables local error termination of unmapped accesses
module dtl_address_decoder #(
   parameter int INTERFACE_WIDTH = 32,
   parameter int INTERFACE_ADDR_WIDTH = 32,
   parameter int INTERFACE_BLOCK_WIDTH = 5,
   parameter int INTERFACE_NUM_ENABLES = INTERFACE_WIDTH / 8,
   parameter int NUM_SLAVES = 4,
   parameter int WINDOW_ADDR_WIDTH = 12,
   parameter logic [INTERFACE_ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
   parameter logic [INTERFACE_WIDTH-1:0] ERROR_DATA = 32'hDEADBEEF
) (
   input  logic                                            iClk,
   input  logic                                            iReset,
   input  logic                                            iDTL_IN_CommandValid,
   output logic                                            oDTL_IN_CommandAccept,
   input  logic [INTERFACE_ADDR_WIDTH-1:0]                 iDTL_IN_Address,
   input  logic                                            iDTL_IN_CommandReadWrite,
   input  logic [INTERFACE_BLOCK_WIDTH-1:0]                iDTL_IN_BlockSize,
   output logic                                            oDTL_IN_ReadValid,
   output logic                                            oDTL_IN_ReadLast,
   input  logic                                            iDTL_IN_ReadAccept,
   output logic [INTERFACE_WIDTH-1:0]                      oDTL_IN_ReadData,
   input  logic                                            iDTL_IN_WriteValid,
   input  logic                                            iDTL_IN_WriteLast,
   output logic                                            oDTL_IN_WriteAccept,
   input  logic [INTERFACE_NUM_ENABLES-1:0]                iDTL_IN_WriteEnable,
   input  logic [INTERFACE_WIDTH-1:0]                      iDTL_IN_WriteData,
   output logic [NUM_SLAVES-1:0]                           oDTL_OUT_CommandValid,
   input  logic [NUM_SLAVES-1:0]                           iDTL_OUT_CommandAccept,
   output logic [NUM_SLAVES*INTERFACE_ADDR_WIDTH-1:0]      oDTL_OUT_Address,
   output logic [NUM_SLAVES-1:0]                           oDTL_OUT_CommandReadWrite,
   output logic [NUM_SLAVES*INTERFACE_BLOCK_WIDTH-1:0]     oDTL_OUT_BlockSize,
   input  logic [NUM_SLAVES-1:0]                           iDTL_OUT_ReadValid,
   input  logic [NUM_SLAVES-1:0]                           iDTL_OUT_ReadLast,
   output logic [NUM_SLAVES-1:0]                           oDTL_OUT_ReadAccept,
   input  logic [NUM_SLAVES*INTERFACE_WIDTH-1:0]           iDTL_OUT_ReadData,
   output logic [NUM_SLAVES-1:0]                           oDTL_OUT_WriteValid,
   output logic [NUM_SLAVES-1:0]                           oDTL_OUT_WriteLast,
   input  logic [NUM_SLAVES-1:0]                           iDTL_OUT_WriteAccept,
   output logic [NUM_SLAVES*INTERFACE_NUM_ENABLES-1:0]     oDTL_OUT_WriteEnable,
   output logic [NUM_SLAVES*INTERFACE_WIDTH-1:0]           oDTL_OUT_WriteData,
   output logic                                            oDTL_Error
);
   localparam int N = NUM_SLAVES;
   localparam int AW = INTERFACE_ADDR_WIDTH;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [2:0] {IDLE, WRITE, READ, ERR_WRITE, ERR_READ} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic err_q, err_d;
`ifdef DTL_DECODER_ERROR_RESP_EN
   logic [INTERFACE_BLOCK_WIDTH-1:0] cnt_q, cnt_d;
`endif
   logic [AW-1:0] off, win;
   logic [IW-1:0] idx;
   logic hit;
   logic [N-1:0] cmd_valid, wr_valid, rd_accept;
   logic cmd_accept, wr_accept, rd_valid, rd_last;
   logic [INTERFACE_WIDTH-1:0] rd_data;
   assign off = iDTL_IN_Address - BASE_ADDRESS;
   assign win = off >> WINDOW_ADDR_WIDTH;
   assign hit = (iDTL_IN_Address >= BASE_ADDRESS) && (win < AW'(N));
   assign idx = win[IW-1:0];
   assign oDTL_OUT_Address = {N{AW'(off[WINDOW_ADDR_WIDTH-1:0])}};
   assign oDTL_OUT_CommandReadWrite = {N{iDTL_IN_CommandReadWrite}};
   assign oDTL_OUT_BlockSize = {N{iDTL_IN_BlockSize}};
   assign oDTL_OUT_WriteEnable = {N{iDTL_IN_WriteEnable}};
   assign oDTL_OUT_WriteData = {N{iDTL_IN_WriteData}};
   assign oDTL_OUT_WriteLast = {N{iDTL_IN_WriteLast}};
   assign oDTL_OUT_CommandValid = iReset ? '0 : cmd_valid;
   assign oDTL_OUT_WriteValid = iReset ? '0 : wr_valid;
   assign oDTL_OUT_ReadAccept = iReset ? '0 : rd_accept;
   assign oDTL_IN_CommandAccept = cmd_accept & ~iReset;
   assign oDTL_IN_WriteAccept = wr_accept & ~iReset;
   assign oDTL_IN_ReadValid = rd_valid & ~iReset;
   assign oDTL_IN_ReadLast = rd_last;
   assign oDTL_IN_ReadData = rd_data;
   assign oDTL_Error = err_q;
   // decode and routing per state; the latched port owns the data channels until the last beat
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      err_d = err_q;
`ifdef DTL_DECODER_ERROR_RESP_EN
      cnt_d = cnt_q;
`endif
      cmd_valid = '0;
      cmd_accept = 1'b0;
      wr_valid = '0;
      wr_accept = 1'b0;
      rd_valid = 1'b0;
      rd_last = 1'b0;
      rd_data = '0;
      rd_accept = '0;
      case (state_q)
         IDLE: begin
            err_d = err_q | (iDTL_IN_CommandValid & ~hit);
            if (hit) begin
               cmd_valid = N'(iDTL_IN_CommandValid) << idx;
               cmd_accept = iDTL_OUT_CommandAccept[idx];
            end
`ifdef DTL_DECODER_ERROR_RESP_EN
            else cmd_accept = iDTL_IN_CommandValid;
            cnt_d = iDTL_IN_BlockSize;
`endif
            if (iDTL_IN_CommandValid && cmd_accept) begin
               idx_d = idx;
`ifdef DTL_DECODER_ERROR_RESP_EN
               state_d = hit ? (iDTL_IN_CommandReadWrite ? READ : WRITE) : (iDTL_IN_CommandReadWrite ? ERR_READ : ERR_WRITE);
`else
               state_d = iDTL_IN_CommandReadWrite ? READ : WRITE;
`endif
            end
         end
         WRITE: begin
            wr_valid = N'(iDTL_IN_WriteValid) << idx_q;
            wr_accept = iDTL_OUT_WriteAccept[idx_q];
            if (iDTL_IN_WriteValid && wr_accept && iDTL_IN_WriteLast) state_d = IDLE;
         end
         READ: begin
            rd_valid = iDTL_OUT_ReadValid[idx_q];
            rd_last = iDTL_OUT_ReadLast[idx_q];
            rd_data = iDTL_OUT_ReadData[idx_q*INTERFACE_WIDTH +: INTERFACE_WIDTH];
            rd_accept = N'(iDTL_IN_ReadAccept) << idx_q;
            if (rd_valid && iDTL_IN_ReadAccept && rd_last) state_d = IDLE;
         end
`ifdef DTL_DECODER_ERROR_RESP_EN
         ERR_WRITE: begin
            wr_accept = 1'b1;
            if (iDTL_IN_WriteValid && iDTL_IN_WriteLast) state_d = IDLE;
         end
         ERR_READ: begin
            rd_valid = 1'b1;
            rd_data = ERROR_DATA;
            rd_last = (cnt_q == '0);
            if (iDTL_IN_ReadAccept) begin
               cnt_d = cnt_q - 1'b1;
               if (rd_last) state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   // state, latched port, sticky error and beat counter
   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q <= IDLE;
         idx_q <= '0;
         err_q <= 1'b0;
`ifdef DTL_DECODER_ERROR_RESP_EN
         cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         err_q <= err_d;
`ifdef DTL_DECODER_ERROR_RESP_EN
         cnt_q <= cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_dtl_address_decoder.sv
// tb_dtl_address_decoder: directed self-checking bench for dtl_address_decoder (4 ports, 4 KiB windows at 0)
module tb_dtl_address_decoder;
   logic clk = 1'b0;
   logic rst;
   logic cv, ca, rw, rv, rl, ra, wv, wl, wa, err;
   logic [31:0] addr, rd, wd;
   logic [4:0] bs;
   logic [3:0] we;
   logic [3:0] o_cv, i_ca, o_rw, i_rv, i_rl, o_ra, o_wv, o_wl, i_wa;
   logic [127:0] o_addr, i_rd, o_wd;
   logic [19:0] o_bs;
   logic [15:0] o_we;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   dtl_address_decoder dut (
      .iClk(clk), .iReset(rst),
      .iDTL_IN_CommandValid(cv), .oDTL_IN_CommandAccept(ca), .iDTL_IN_Address(addr),
      .iDTL_IN_CommandReadWrite(rw), .iDTL_IN_BlockSize(bs),
      .oDTL_IN_ReadValid(rv), .oDTL_IN_ReadLast(rl), .iDTL_IN_ReadAccept(ra), .oDTL_IN_ReadData(rd),
      .iDTL_IN_WriteValid(wv), .iDTL_IN_WriteLast(wl), .oDTL_IN_WriteAccept(wa),
      .iDTL_IN_WriteEnable(we), .iDTL_IN_WriteData(wd),
      .oDTL_OUT_CommandValid(o_cv), .iDTL_OUT_CommandAccept(i_ca), .oDTL_OUT_Address(o_addr),
      .oDTL_OUT_CommandReadWrite(o_rw), .oDTL_OUT_BlockSize(o_bs),
      .iDTL_OUT_ReadValid(i_rv), .iDTL_OUT_ReadLast(i_rl), .oDTL_OUT_ReadAccept(o_ra), .iDTL_OUT_ReadData(i_rd),
      .oDTL_OUT_WriteValid(o_wv), .oDTL_OUT_WriteLast(o_wl), .iDTL_OUT_WriteAccept(i_wa),
      .oDTL_OUT_WriteEnable(o_we), .oDTL_OUT_WriteData(o_wd),
      .oDTL_Error(err)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // advance to 1 time unit after the next rising edge; checks happen at the following falling edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic settle();
      #4;
   endtask
   task automatic cmd(input logic [31:0] a, input logic r, input logic [4:0] b);
      cv = 1'b1; addr = a; rw = r; bs = b;
   endtask
   initial begin
      rst = 1'b1; cv = 0; addr = 0; rw = 0; bs = 0; ra = 0; wv = 0; wl = 0; we = 4'hF; wd = 32'h0;
      i_ca = 4'hF; i_rv = 4'hF; i_rl = 0; i_rd = '0; i_wa = 4'hF;
      cmd(32'h1004, 1'b0, 5'd3);
      wv = 1'b1; ra = 1'b1;
      step(); settle();
      chk("rst_cmd_accept", ca, 0);
      chk("rst_cmd_valid", o_cv, 0);
      chk("rst_wr_valid", o_wv, 0);
      chk("rst_wr_accept", wa, 0);
      chk("rst_rd_valid", rv, 0);
      chk("rst_error", err, 0);
      // write, 4 beats to port 1, first beat offered in the command cycle
      step();
      rst = 1'b0; ra = 0; wv = 1'b1; wl = 0; wd = 32'hA5A5_0000;
      i_ca = 4'b0010; i_wa = 4'b0010; i_rv = 0;
      settle();
      chk("wr_cmd_valid", o_cv, 4'b0010);
      chk("wr_cmd_accept", ca, 1);
      chk("wr_addr_p1", o_addr[32 +: 32], 32'h004);
      chk("wr_bs_bcast", o_bs[15 +: 5], 5'd3);
      chk("wr_same_cycle_beat", wa, 0);
      chk("wr_same_cycle_wv", o_wv, 0);
      for (int b = 0; b < 4; b++) begin
         step();
         cv = 0; wv = 1'b1; wl = (b == 3); wd = 32'hA5A5_0000 + b;
         i_ca = 4'hF;
         settle();
         chk($sformatf("wr_beat%0d_wv", b), o_wv, 4'b0010);
         chk($sformatf("wr_beat%0d_wa", b), wa, 1);
         chk($sformatf("wr_beat%0d_data", b), o_wd[32 +: 32], 32'hA5A5_0000 + b);
         chk($sformatf("wr_beat%0d_cmd_blocked", b), o_cv, 0);
      end
      // back in IDLE: read of 0x3FFC to port 3
      step();
      wv = 1'b1; wl = 0; cmd(32'h3FFC, 1'b1, 5'd0); i_ca = 4'b1000;
      settle();
      chk("idle_after_wr_wa", wa, 0);
      chk("rd3_cmd_valid", o_cv, 4'b1000);
      chk("rd3_cmd_accept", ca, 1);
      chk("rd3_addr", o_addr[96 +: 32], 32'hFFC);
      // read data held by port 3, master not accepting for 2 cycles; new command to port 0 pending
      for (int c = 0; c < 3; c++) begin
         step();
         wv = 0; cmd(32'h0000_0010, 1'b1, 5'd1); i_ca = 4'hF;
         i_rv = 4'b1000; i_rl = 4'b1000; i_rd = '0; i_rd[96 +: 32] = 32'hCAFE_F00D;
         ra = (c == 2);
         settle();
         chk($sformatf("rd3_c%0d_rv", c), rv, 1);
         chk($sformatf("rd3_c%0d_data", c), rd, 32'hCAFE_F00D);
         chk($sformatf("rd3_c%0d_last", c), rl, 1);
         chk($sformatf("rd3_c%0d_ra", c), o_ra, (c == 2) ? 4'b1000 : 4'b0000);
         chk($sformatf("rd3_c%0d_cmd_accept", c), ca, 0);
         chk($sformatf("rd3_c%0d_cmd_valid", c), o_cv, 0);
      end
      step();
      i_rv = 0; i_rl = 0; ra = 0; i_ca = 4'b0001;
      settle();
      chk("rd0_cmd_accept", ca, 1);
      chk("rd0_cmd_valid", o_cv, 4'b0001);
      chk("rd0_addr", o_addr[0 +: 32], 32'h10);
      chk("idle_rd_valid", rv, 0);
      // port-0 read of 2 beats while a write to 0x2000 waits
      for (int b = 0; b < 2; b++) begin
         step();
         cmd(32'h2000, 1'b0, 5'd3); i_ca = 4'hF;
         i_rv = 4'b0001; i_rl = (b == 1) ? 4'b0001 : 4'b0000;
         i_rd = {4{32'h1111_0000 + b}}; ra = 1'b1;
         settle();
         chk($sformatf("rd0_beat%0d_data", b), rd, 32'h1111_0000 + b);
         chk($sformatf("rd0_beat%0d_last", b), rl, (b == 1));
         chk($sformatf("rd0_beat%0d_cmd_accept", b), ca, 0);
      end
      step();
      i_rv = 0; i_rl = 0; ra = 0; i_ca = 4'b0100;
      settle();
      chk("wr2_cmd_accept", ca, 1);
      chk("wr2_cmd_valid", o_cv, 4'b0100);
      // write to port 2 abandoned by reset during beat 2
      step();
      cv = 0; wv = 1'b1; wl = 0; i_wa = 4'b0100;
      settle();
      chk("wr2_beat1_wv", o_wv, 4'b0100);
      step();
      rst = 1'b1;
      settle();
      chk("wr2_rst_wv", o_wv, 0);
      chk("wr2_rst_wa", wa, 0);
      chk("wr2_rst_rv", rv, 0);
      step();
      rst = 1'b0; wv = 0; cmd(32'h1000, 1'b0, 5'd0); i_ca = 4'b0010;
      settle();
      chk("post_rst_cmd_valid", o_cv, 4'b0010);
      chk("post_rst_cmd_accept", ca, 1);
      chk("post_rst_error", err, 0);
      step();
      cv = 0; wv = 1'b1; wl = 1'b1; i_wa = 4'b0010;
      settle();
      chk("post_rst_wa", wa, 1);
      // window boundary
      step();
      wv = 0; wl = 0; cmd(32'h3FFF, 1'b1, 5'd0); i_ca = 4'b0000;
      settle();
      chk("top_hit_valid", o_cv, 4'b1000);
      chk("top_hit_addr", o_addr[96 +: 32], 32'hFFF);
      chk("top_hit_no_accept", ca, 0);
      step();
      cmd(32'h4000, 1'b1, 5'd2); i_ca = 4'hF;
      settle();
      chk("miss_no_port_valid", o_cv, 0);
`ifdef DTL_DECODER_ERROR_RESP_EN
      chk("miss_accept", ca, 1);
      step();
      cv = 0; ra = 1'b1; i_rv = 4'hF; i_rl = 4'hF;
      for (int b = 0; b < 3; b++) begin
         if (b > 0) step();
         settle();
         chk($sformatf("err_rd%0d_rv", b), rv, 1);
         chk($sformatf("err_rd%0d_data", b), rd, 32'hDEAD_BEEF);
         chk($sformatf("err_rd%0d_last", b), rl, (b == 2));
         chk($sformatf("err_rd%0d_ra", b), o_ra, 0);
         chk($sformatf("err_rd%0d_error", b), err, 1);
      end
      step();
      ra = 0; i_rv = 0; i_rl = 0; cmd(32'h5000, 1'b0, 5'd1);
      settle();
      chk("err_rd_done_rv", rv, 0);
      chk("err_wr_accept_cmd", ca, 1);
      for (int b = 0; b < 2; b++) begin
         step();
         cv = 0; wv = 1'b1; wl = (b == 1); i_wa = 4'h0;
         settle();
         chk($sformatf("err_wr%0d_wa", b), wa, 1);
         chk($sformatf("err_wr%0d_wv", b), o_wv, 0);
      end
      step();
      wv = 1'b1; wl = 0;
      settle();
      chk("err_wr_done_wa", wa, 0);
      chk("err_sticky", err, 1);
`else
      chk("miss_no_accept", ca, 0);
      step();
      settle();
      chk("miss_error_set", err, 1);
      chk("miss_still_stalled", ca, 0);
      chk("miss_still_no_valid", o_cv, 0);
      step();
      cv = 0;
      settle();
      chk("miss_error_sticky", err, 1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
